// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : UART-style transmitter draining a show-ahead FIFO read port:
//            start bit, WIDTH data bits LSB first, one stop bit per word.
// Revision : 1.0
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             re,
    output logic             tx,
    output logic             busy
);

    localparam int c_tick_w = $clog2(CLKS_PER_BIT) + 1;
    localparam int c_bit_w  = $clog2(WIDTH) + 1;

    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_bit_max  = c_bit_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0,
                           c_st_start = 2'd1,
                           c_st_data  = 2'd2,
                           c_st_stop  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_tick_w-1:0] r_tick;
    logic [c_bit_w-1:0]  r_bit;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    w_shift_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_tick_done;
    logic                w_last_bit;

    assign w_tick_done = (r_tick == c_tick_max);
    assign w_last_bit  = (r_bit == c_bit_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (!empty)                    w_state_next = c_st_start;
            c_st_start: if (w_tick_done)               w_state_next = c_st_data;
            c_st_data:  if (w_tick_done && w_last_bit) w_state_next = c_st_stop;
            c_st_stop:  if (w_tick_done)               w_state_next = c_st_idle;
            default:                                   w_state_next = c_st_idle;
        endcase
    end

    // tx is registered, so its next value is derived from the next state and next shift contents
    always_comb begin
        re           = (r_state == c_st_idle) && !empty && !rst;
        busy         = (r_state != c_st_idle);
        w_shift_next = r_shift;
        if ((r_state == c_st_idle) && !empty) begin
            w_shift_next = rdata;
        end else if ((r_state == c_st_data) && w_tick_done) begin
            w_shift_next = r_shift >> 1;
        end
        case (w_state_next)
            c_st_start: w_tx_next = 1'b0;
            c_st_data:  w_tx_next = w_shift_next[0];
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if ((r_state == c_st_idle) || w_tick_done) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
            if (r_state != c_st_data) begin
                r_bit <= '0;
            end else if (w_tick_done) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Self-checking bench for fifo_uart_tx against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_w       = 4;
    localparam int c_cpb     = 4;
    localparam int c_frame   = (c_w + 2) * c_cpb;
    localparam int c_frame1  = c_w + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           empty;
    logic [c_w-1:0] rdata;
    logic           re;
    logic           tx;
    logic           busy;
    logic           empty1;
    logic [c_w-1:0] rdata1;
    logic           re1;
    logic           tx1;
    logic           busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(c_w), .CLKS_PER_BIT(c_cpb)) u_dut (
        .clk(clk), .rst(rst), .empty(empty), .rdata(rdata),
        .re(re), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.WIDTH(c_w), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .empty(empty1), .rdata(rdata1),
        .re(re1), .tx(tx1), .busy(busy1)
    );

    // Serial line level k cycles after the first START cycle of a frame carrying d
    function automatic logic exp_tx(input logic [c_w-1:0] d, input int k, input int cpb);
        int idx;
        idx = k / cpb;
        if (idx == 0) return 1'b0;
        else if (idx <= c_w) return d[idx-1];
        else return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; empty = 1'b1; rdata = '0; empty1 = 1'b1; rdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || re !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state tx=%b re=%b busy=%b expected tx=1 re=0 busy=0", tx, re, busy);
        end
        checks++;
        if (tx1 !== 1'b1 || re1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_cpb1 tx=%b re=%b busy=%b expected tx=1 re=0 busy=0", tx1, re1, busy1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || re !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d tx=%b re=%b busy=%b expected tx=1 re=0 busy=0", i, tx, re, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [c_w-1:0] words [4];
        int re_cnt;
        words[0] = 4'hA;
        for (int i = 1; i < 4; i++) words[i] = c_w'($urandom);
        for (int n = 0; n < 4; n++) begin
            re_cnt = 0;
            @(posedge clk); #1;
            empty = 1'b0; rdata = words[n];
            @(negedge clk);
            if (re === 1'b1) re_cnt++;
            checks++;
            if (re !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_pop word=%h re=%b busy=%b expected re=1 busy=0", words[n], re, busy);
            end
            @(posedge clk); #1;
            empty = 1'b1; rdata = c_w'($urandom);
            for (int k = 0; k < c_frame; k++) begin
                @(negedge clk);
                if (re === 1'b1) re_cnt++;
                checks++;
                if (tx !== exp_tx(words[n], k, c_cpb) || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL single_tx word=%h k=%0d tx=%b busy=%b expected tx=%b busy=1",
                             words[n], k, tx, busy, exp_tx(words[n], k, c_cpb));
                end
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || re !== 1'b0) begin
                failures++;
                $display("FAIL single_end tx=%b busy=%b re=%b expected tx=1 busy=0 re=0", tx, busy, re);
            end
            checks++;
            if (re_cnt != 1) begin
                failures++;
                $display("FAIL single_re_pulses got=%0d expected=1", re_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [c_w-1:0] q[$];
        logic [c_w-1:0] words[$];
        int n_words, re_cnt, pos, idx;
        logic popping, exp_t, exp_r, exp_b;
        q.push_back(4'h3);
        q.push_back(4'hC);
        q.push_back(c_w'($urandom));
        q.push_back(c_w'($urandom));
        words = q;
        n_words = q.size();
        re_cnt = 0;
        @(posedge clk); #1;
        empty = 1'b0; rdata = q[0];
        @(negedge clk);
        popping = re;
        if (re === 1'b1) re_cnt++;
        checks++;
        if (re !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_pop re=%b expected 1", re);
        end
        for (int c = 0; c < n_words * (c_frame + 1); c++) begin
            @(posedge clk); #1;
            if (popping === 1'b1 && q.size() > 0) void'(q.pop_front());
            empty = (q.size() == 0);
            rdata = (q.size() > 0) ? q[0] : c_w'($urandom);
            @(negedge clk);
            popping = re;
            if (re === 1'b1) re_cnt++;
            pos = c % (c_frame + 1);
            idx = c / (c_frame + 1);
            if (pos < c_frame) begin
                exp_t = exp_tx(words[idx], pos, c_cpb); exp_r = 1'b0; exp_b = 1'b1;
            end else begin
                exp_t = 1'b1; exp_b = 1'b0; exp_r = (idx + 1 < n_words);
            end
            checks++;
            if (tx !== exp_t || re !== exp_r || busy !== exp_b) begin
                failures++;
                $display("FAIL b2b cycle=%0d tx=%b re=%b busy=%b expected tx=%b re=%b busy=%b",
                         c, tx, re, busy, exp_t, exp_r, exp_b);
            end
        end
        checks++;
        if (re_cnt != n_words) begin
            failures++;
            $display("FAIL b2b_re_pulses got=%0d expected=%0d", re_cnt, n_words);
        end
    endtask

    task automatic test_pop_isolation();
        logic [c_w-1:0] d0, d1;
        d0 = c_w'($urandom);
        d1 = c_w'($urandom);
        @(posedge clk); #1;
        empty = 1'b0; rdata = d0;
        @(negedge clk);
        checks++;
        if (re !== 1'b1) begin
            failures++;
            $display("FAIL iso_pop re=%b expected 1", re);
        end
        for (int k = 0; k < c_frame; k++) begin
            @(posedge clk); #1;
            empty = 1'b0; rdata = c_w'($urandom);
            @(negedge clk);
            checks++;
            if (tx !== exp_tx(d0, k, c_cpb) || re !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL iso_frame k=%0d tx=%b re=%b busy=%b expected tx=%b re=0 busy=1",
                         k, tx, re, busy, exp_tx(d0, k, c_cpb));
            end
        end
        @(posedge clk); #1;
        empty = 1'b0; rdata = d1;
        @(negedge clk);
        checks++;
        if (re !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL iso_idle_pop re=%b busy=%b tx=%b expected re=1 busy=0 tx=1", re, busy, tx);
        end
        for (int k = 0; k < c_frame; k++) begin
            @(posedge clk); #1;
            empty = 1'($urandom_range(0, 1)); rdata = c_w'($urandom);
            @(negedge clk);
            checks++;
            if (tx !== exp_tx(d1, k, c_cpb) || re !== 1'b0) begin
                failures++;
                $display("FAIL iso_second k=%0d tx=%b re=%b expected tx=%b re=0",
                         k, tx, re, exp_tx(d1, k, c_cpb));
            end
        end
        @(posedge clk); #1;
        empty = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || re !== 1'b0) begin
            failures++;
            $display("FAIL iso_end busy=%b tx=%b re=%b expected busy=0 tx=1 re=0", busy, tx, re);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [c_w-1:0] d0, d1;
        d0 = c_w'($urandom);
        d1 = c_w'($urandom);
        @(posedge clk); #1;
        empty = 1'b0; rdata = d0;
        @(posedge clk); #1;
        empty = 1'b1;
        // land mid-way through data bit 2
        for (int k = 0; k <= 3 * c_cpb + 1; k++) @(negedge clk);
        checks++;
        if (tx !== d0[2]) begin
            failures++;
            $display("FAIL midrst_prebit tx=%b expected %b", tx, d0[2]);
        end
        #1;
        rst = 1'b1; empty = 1'b0; rdata = d1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || re !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async tx=%b busy=%b re=%b expected tx=1 busy=0 re=0", tx, busy, re);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (re !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pop re=%b busy=%b tx=%b expected re=1 busy=0 tx=1", re, busy, tx);
        end
        @(posedge clk); #1;
        empty = 1'b1;
        for (int k = 0; k < c_frame; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== exp_tx(d1, k, c_cpb) || busy !== 1'b1) begin
                failures++;
                $display("FAIL midrst_frame k=%0d tx=%b busy=%b expected tx=%b busy=1",
                         k, tx, busy, exp_tx(d1, k, c_cpb));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL midrst_end busy=%b tx=%b expected busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_cpb1();
        logic [c_w-1:0] words [3];
        words[0] = 4'h5;
        words[1] = c_w'($urandom);
        words[2] = c_w'($urandom);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            empty1 = 1'b0; rdata1 = words[n];
            @(negedge clk);
            checks++;
            if (re1 !== 1'b1) begin
                failures++;
                $display("FAIL cpb1_pop re=%b expected 1", re1);
            end
            for (int k = 0; k < c_frame1; k++) begin
                @(negedge clk);
                checks++;
                if (tx1 !== exp_tx(words[n], k, 1) || re1 !== 1'b0 || busy1 !== 1'b1) begin
                    failures++;
                    $display("FAIL cpb1_frame word=%h k=%0d tx=%b re=%b busy=%b expected tx=%b re=0 busy=1",
                             words[n], k, tx1, re1, busy1, exp_tx(words[n], k, 1));
                end
            end
            @(negedge clk);
            checks++;
            if (re1 !== 1'b1 || busy1 !== 1'b0 || tx1 !== 1'b1) begin
                failures++;
                $display("FAIL cpb1_repop re=%b busy=%b tx=%b expected re=1 busy=0 tx=1", re1, busy1, tx1);
            end
            @(posedge clk); #1;
            empty1 = 1'b1;
            for (int k = 0; k < c_frame1; k++) begin
                @(negedge clk);
                checks++;
                if (tx1 !== exp_tx(words[n], k, 1) || re1 !== 1'b0) begin
                    failures++;
                    $display("FAIL cpb1_second word=%h k=%0d tx=%b re=%b expected tx=%b re=0",
                             words[n], k, tx1, re1, exp_tx(words[n], k, 1));
                end
            end
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b0 || tx1 !== 1'b1 || re1 !== 1'b0) begin
                failures++;
                $display("FAIL cpb1_end busy=%b tx=%b re=%b expected busy=0 tx=1 re=0", busy1, tx1, re1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_pop_isolation();
        test_reset_mid_frame();
        test_cpb1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
